// File: rtl/enc7_led_pkg.sv
// Shared types, glyph constants and lookup helper for the 7-segment encoder.
// All segment constants are active-low: a 0 bit lights the segment.
// Bit order is leds[0]=a .. leds[6]=g.
package enc7_led_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned N_GLYPH = 16;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [NIB_W-1:0] nib_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_ALL   = 7'h00;

    // Highest nibble that has a decimal glyph.
    localparam nib_t DEC_MAX = 4'd9;

    // Hex glyphs 0-9, A b C d E F.
    localparam seg_t HEX_GLYPH [N_GLYPH] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Glyph for a nibble; decimal mode shows a dash above 9.
    function automatic seg_t glyph(input nib_t nib, input logic hex_mode);
        seg_t g;
        g = HEX_GLYPH[nib];
        if (!hex_mode && (nib > DEC_MAX)) begin
            g = SEG_DASH;
        end
        return g;
    endfunction

    // Map an active-low pattern onto the requested output polarity.
    function automatic seg_t to_polarity(input seg_t seg_low, input logic active_low);
        return active_low ? seg_low : seg_t'(~seg_low);
    endfunction

endpackage

// File: rtl/enc7_led_if.sv
// Digit bus between a status source and one encoder instance.
// Optional lamp_test signal exists only when ENC7LED_LAMP_TEST_EN is defined.
interface enc7_led_if;
    import enc7_led_pkg::*;

    nib_t vinp;
    logic enchx;
`ifdef ENC7LED_LAMP_TEST_EN
    logic lamp_test;
`endif
    seg_t leds;

`ifdef ENC7LED_LAMP_TEST_EN
    modport master (output vinp, output enchx, output lamp_test, input leds);
    modport slave  (input vinp, input enchx, input lamp_test, output leds);
`else
    modport master (output vinp, output enchx, input leds);
    modport slave  (input vinp, input enchx, output leds);
`endif

endinterface

// File: rtl/enc7_led_rom.sv
// Combinational nibble-to-glyph lookup, active-low result.
module enc7_led_rom
    import enc7_led_pkg::*;
(
    input  nib_t vinp,
    input  logic enchx,
    output seg_t seg_c
);

    // Table lookup with decimal-mode dash substitution.
    always_comb begin
        seg_c = glyph(vinp, enchx);
    end

endmodule

// File: rtl/enc7_led.sv
// Registered 4-bit to 7-segment encoder for one HEX digit.
// ACTIVE_LOW=1 drives DE1-SoC style displays (0 lights a segment);
// ACTIVE_LOW=0 inverts every output bit, blank included.
// Optional: define ENC7LED_LAMP_TEST_EN to add the lamp_test input,
// which lights all segments; reset still takes priority.
module enc7_led
    import enc7_led_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       sysclk,
    input  logic       rst,
    enc7_led_if.slave  bus
);

    seg_t glyph_c;
    seg_t sel_c;
    seg_t pol_c;
    seg_t blank_c;
    seg_t leds_q;

    enc7_led_rom u_rom (
        .vinp  (bus.vinp),
        .enchx (bus.enchx),
        .seg_c (glyph_c)
    );

    // Lamp-test override ahead of the polarity stage.
    always_comb begin
        sel_c = glyph_c;
`ifdef ENC7LED_LAMP_TEST_EN
        if (bus.lamp_test) begin
            sel_c = SEG_ALL;
        end
`endif
    end

    // Polarity stage for both the glyph and the reset blank.
    always_comb begin
        pol_c   = to_polarity(sel_c, ACTIVE_LOW);
        blank_c = to_polarity(SEG_BLANK, ACTIVE_LOW);
    end

    // Output register; reset blanks the digit and wins over everything.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            leds_q <= blank_c;
        end else begin
            leds_q <= pol_c;
        end
    end

    assign bus.leds = leds_q;

endmodule

// File: tb/tb_enc7_led.sv
// Directed bench for enc7_led: one active-low and one active-high instance
// driven with identical stimulus. Lamp-test vectors are included when
// ENC7LED_LAMP_TEST_EN is defined.
module tb_enc7_led;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    enc7_led_if bus_lo ();
    enc7_led_if bus_hi ();

    enc7_led #(.ACTIVE_LOW(1'b1)) dut_lo (.sysclk(sysclk), .rst(rst), .bus(bus_lo));
    enc7_led #(.ACTIVE_LOW(1'b0)) dut_hi (.sysclk(sysclk), .rst(rst), .bus(bus_hi));

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic       rst;
        logic [3:0] vinp;
        logic       enchx;
        logic       lamp;
        logic [6:0] exp_lo;
        string      name;
    } vec_t;

    // Reference glyphs, active-low, written out independently of the design.
    logic [6:0] ref_hex [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 7'h%02h expected 7'h%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic hx, input logic lamp);
        rst          = r;
        bus_lo.vinp  = v;
        bus_lo.enchx = hx;
        bus_hi.vinp  = v;
        bus_hi.enchx = hx;
`ifdef ENC7LED_LAMP_TEST_EN
        bus_lo.lamp_test = lamp;
        bus_hi.lamp_test = lamp;
`else
        if (lamp) $display("note: lamp vector without lamp-test build");
`endif
    endtask

    // Apply inputs now, let one edge pass, sample 1 time unit later.
    task automatic step(input logic r, input logic [3:0] v, input logic hx, input logic lamp);
        drive(r, v, hx, lamp);
        @(posedge sysclk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic hx,
                                input logic lamp, input logic [6:0] e, input string n);
        vec_t t;
        t.rst = r; t.vinp = v; t.enchx = hx; t.lamp = lamp; t.exp_lo = e; t.name = n;
        return t;
    endfunction

    initial begin
        drive(1'b1, 4'h8, 1'b1, 1'b0);

        // Reset held two cycles with a live nibble, then release.
        step(1'b1, 4'h8, 1'b1, 1'b0);
        chk("rst_c1_lo", bus_lo.leds, 7'h7F);
        chk("rst_c1_hi", bus_hi.leds, 7'h00);
        step(1'b1, 4'h8, 1'b1, 1'b0);
        chk("rst_c2_lo", bus_lo.leds, 7'h7F);
        chk("rst_c2_hi", bus_hi.leds, 7'h00);
        step(1'b0, 4'h8, 1'b1, 1'b0);
        chk("rel_8_lo", bus_lo.leds, 7'h00);
        chk("rel_8_hi", bus_hi.leds, 7'h7F);

        // Hex sweep.
        for (int i = 0; i < 16; i++) begin
            vq.push_back(mk(1'b0, 4'(i), 1'b1, 1'b0, ref_hex[i], $sformatf("hex_%0h", i)));
        end
        // Decimal sweep: dash above 9.
        for (int i = 0; i < 16; i++) begin
            vq.push_back(mk(1'b0, 4'(i), 1'b0, 1'b0, (i > 9) ? 7'h3F : ref_hex[i],
                            $sformatf("dec_%0h", i)));
        end
        // Mode switch on the same nibble.
        vq.push_back(mk(1'b0, 4'h9, 1'b0, 1'b0, 7'h10, "dec_9"));
        vq.push_back(mk(1'b0, 4'hC, 1'b0, 1'b0, 7'h3F, "dec_c_dash"));
        vq.push_back(mk(1'b0, 4'hC, 1'b1, 1'b0, 7'h46, "hex_c_after_dec"));
        // Active-high reference point, then reset blank.
        vq.push_back(mk(1'b0, 4'h1, 1'b1, 1'b0, 7'h79, "one"));
        vq.push_back(mk(1'b1, 4'h1, 1'b1, 1'b0, 7'h7F, "rst_one"));
        // Mid-sweep single-cycle reset.
        vq.push_back(mk(1'b0, 4'h4, 1'b1, 1'b0, 7'h19, "mid_4"));
        vq.push_back(mk(1'b1, 4'h5, 1'b1, 1'b0, 7'h7F, "mid_rst_5"));
        vq.push_back(mk(1'b0, 4'h5, 1'b1, 1'b0, 7'h12, "mid_5"));
        vq.push_back(mk(1'b0, 4'h6, 1'b1, 1'b0, 7'h02, "mid_6"));
`ifdef ENC7LED_LAMP_TEST_EN
        vq.push_back(mk(1'b0, 4'h1, 1'b1, 1'b1, 7'h00, "lamp_1"));
        vq.push_back(mk(1'b0, 4'hE, 1'b0, 1'b1, 7'h00, "lamp_dec_e"));
        vq.push_back(mk(1'b1, 4'h1, 1'b1, 1'b1, 7'h7F, "lamp_rst"));
        vq.push_back(mk(1'b0, 4'h1, 1'b1, 1'b0, 7'h79, "lamp_off"));
`endif

        foreach (vq[k]) begin
            step(vq[k].rst, vq[k].vinp, vq[k].enchx, vq[k].lamp);
            chk({vq[k].name, "_lo"}, bus_lo.leds, vq[k].exp_lo);
            chk({vq[k].name, "_hi"}, bus_hi.leds, ~vq[k].exp_lo);
        end

        // Explicit active-high spot checks.
        step(1'b0, 4'h1, 1'b1, 1'b0);
        chk("ah_one", bus_hi.leds, 7'h06);
        step(1'b1, 4'h1, 1'b1, 1'b0);
        chk("ah_rst", bus_hi.leds, 7'h00);

        // Output holds between edges.
        step(1'b0, 4'h3, 1'b1, 1'b0);
        drive(1'b0, 4'hA, 1'b1, 1'b0);
        #2;
        chk("hold_3", bus_lo.leds, 7'h30);
        @(posedge sysclk);
        #1;
        chk("after_hold_a", bus_lo.leds, 7'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
